// File: rtl/memory_access.sv
// memory_access: memory stage of the five-stage MIPS pipeline.
//
// Takes one execute-stage record at a time. Loads and stores are issued to
// data memory over a valid/addr_ok/data_ok handshake; every other record
// (including misaligned accesses) completes directly. A completed record is
// handed to writeback with a one-cycle writeback_enable pulse, together with
// the aligned/extended load data and the E/M select.
//
// Ports:
//   clk, reset             clock; asynchronous active-low reset
//   in_valid, in_ready     record handshake with the execute stage
//   flush                  blocks acceptance while idle
//   execute_data_reg       incoming execute record
//   dreq_*                 data memory request (valid/addr/write/strobe/wdata)
//   dresp_*                data memory response (addr_ok/data_ok/rdata)
//   writeback_enable       one-cycle pulse when a record completes
//   m_or_e                 SEL_M for completed loads/stores, SEL_E otherwise
//   read_data              aligned, extended load data (0 for non-loads)
//   memory_data_reg        completed record, memory view
//   execute_data_out       completed record, execute view
//   stall                  front of pipeline must hold (transaction outstanding)
//   addr_error             one-cycle pulse on a misaligned access

package common;
  typedef logic [31:0] u32;
endpackage

package pipes;
  typedef struct packed {
    common::u32 pc;
    common::u32 instruction;
    common::u32 alu_result;
    common::u32 rt_value;
    logic [4:0] write_reg;
    logic       reg_write;
    logic       mem_to_reg;
  } execute_data_t;

  typedef struct packed {
    common::u32 pc;
    common::u32 instruction;
    common::u32 alu_result;
    logic [4:0] write_reg;
    logic       reg_write;
    logic       mem_to_reg;
  } memory_data_t;

  localparam logic SEL_E = 1'b0;
  localparam logic SEL_M = 1'b1;
endpackage

module memory_access
  import common::*;
  import pipes::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  input  execute_data_t execute_data_reg,
  output logic          dreq_valid,
  output logic [31:0]   dreq_addr,
  output logic          dreq_write,
  output logic [3:0]    dreq_strobe,
  output logic [31:0]   dreq_wdata,
  input  logic          dresp_addr_ok,
  input  logic          dresp_data_ok,
  input  logic [31:0]   dresp_rdata,
  output logic          writeback_enable,
  output logic          m_or_e,
  output u32            read_data,
  output memory_data_t  memory_data_reg,
  output execute_data_t execute_data_out,
  output logic          stall,
  output logic          addr_error
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state, state_next;
  execute_data_t rec;
  execute_data_t done_rec;
  memory_data_t  done_mem;
  logic [5:0]    in_op, done_op;
  u32            in_addr, load_data;
  logic          in_load, in_store, in_mem, in_mis;
  logic          accept, start_mem, direct_done, mem_done, complete;
  logic [3:0]    store_strobe;
  u32            store_wdata;

  function automatic logic op_is_load(input logic [5:0] op);
    return (op == 6'h20) || (op == 6'h24) || (op == 6'h21) ||
           (op == 6'h25) || (op == 6'h23);
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == 6'h28) || (op == 6'h29) || (op == 6'h2b);
  endfunction

  function automatic logic op_misaligned(input logic [5:0] op, input logic [1:0] a);
    case (op)
      6'h21, 6'h25, 6'h29: return a[0];
      6'h23, 6'h2b:        return a != 2'b00;
      default:             return 1'b0;
    endcase
  endfunction

  // The addressed byte/halfword is brought down to bit 0, then extended.
  function automatic u32 align_load(input logic [5:0] op, input logic [1:0] a,
                                    input u32 rdata);
    u32 shifted;
    shifted = rdata >> {a, 3'b000};
    case (op)
      6'h20:   return {{24{shifted[7]}}, shifted[7:0]};
      6'h24:   return {24'b0, shifted[7:0]};
      6'h21:   return {{16{shifted[15]}}, shifted[15:0]};
      6'h25:   return {16'b0, shifted[15:0]};
      default: return shifted;
    endcase
  endfunction

  assign in_op    = execute_data_reg.instruction[31:26];
  assign in_addr  = execute_data_reg.alu_result;
  assign in_load  = op_is_load(in_op);
  assign in_store = op_is_store(in_op);
  assign in_mem   = in_load || in_store;
  assign in_mis   = op_misaligned(in_op, in_addr[1:0]);

  assign in_ready   = (state == IDLE);
  assign stall      = (state != IDLE);
  assign dreq_valid = (state == ADDR);

  assign accept      = in_ready && in_valid && !flush;
  assign start_mem   = accept && in_mem && !in_mis;
  assign direct_done = accept && !start_mem;
  assign mem_done    = ((state == ADDR) && dresp_addr_ok && dresp_data_ok) ||
                       ((state == DATA) && dresp_data_ok);
  assign complete    = direct_done || mem_done;

  // Direct completions come from the incoming record; memory completions
  // come from the record held since acceptance.
  assign done_rec  = (state == IDLE) ? execute_data_reg : rec;
  assign done_op   = done_rec.instruction[31:26];
  assign load_data = align_load(done_op, done_rec.alu_result[1:0], dresp_rdata);

  always_comb begin
    done_mem            = '0;
    done_mem.pc          = done_rec.pc;
    done_mem.instruction = done_rec.instruction;
    done_mem.alu_result  = done_rec.alu_result;
    done_mem.write_reg   = done_rec.write_reg;
    done_mem.reg_write   = done_rec.reg_write;
    done_mem.mem_to_reg  = done_rec.mem_to_reg;
  end

  // Store data is replicated across lanes; the strobe picks the live bytes.
  always_comb begin
    store_strobe = 4'b0000;
    store_wdata  = execute_data_reg.rt_value;
    case (in_op)
      6'h28: begin
        store_strobe = 4'b0001 << in_addr[1:0];
        store_wdata  = {4{execute_data_reg.rt_value[7:0]}};
      end
      6'h29: begin
        store_strobe = 4'b0011 << in_addr[1:0];
        store_wdata  = {2{execute_data_reg.rt_value[15:0]}};
      end
      6'h2b: store_strobe = 4'b1111;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // data_ok is only honoured once the address phase has been accepted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_mem) state_next = ADDR;
      ADDR: if (dresp_addr_ok) state_next = dresp_data_ok ? IDLE : DATA;
      DATA: if (dresp_data_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured at acceptance so they stay stable in ADDR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rec         <= '0;
      dreq_addr   <= '0;
      dreq_write  <= 1'b0;
      dreq_strobe <= 4'b0000;
      dreq_wdata  <= '0;
    end else if (start_mem) begin
      rec         <= execute_data_reg;
      dreq_addr   <= {in_addr[31:2], 2'b00};
      dreq_write  <= in_store;
      dreq_strobe <= store_strobe;
      dreq_wdata  <= store_wdata;
    end
  end

  // Completion outputs hold until the next completion; the pulses last one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      writeback_enable <= 1'b0;
      addr_error       <= 1'b0;
      m_or_e           <= SEL_E;
      read_data        <= '0;
      memory_data_reg  <= '0;
      execute_data_out <= '0;
    end else begin
      writeback_enable <= complete;
      addr_error       <= direct_done && in_mem;
      if (complete) begin
        execute_data_out <= done_rec;
        memory_data_reg  <= done_mem;
        m_or_e           <= mem_done ? SEL_M : SEL_E;
        read_data        <= (mem_done && op_is_load(done_op)) ? load_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: randomized scoreboard bench for memory_access.
// The driver issues records and plays the memory side; a separate monitor
// pops expected writebacks and compares them whenever writeback_enable is seen.

module tb_memory_access;
  import common::*;
  import pipes::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, flush;
  execute_data_t execute_data_reg;
  logic          dreq_valid, dreq_write;
  logic [31:0]   dreq_addr, dreq_wdata;
  logic [3:0]    dreq_strobe;
  logic          dresp_addr_ok, dresp_data_ok;
  logic [31:0]   dresp_rdata;
  logic          writeback_enable, m_or_e, stall, addr_error;
  u32            read_data;
  memory_data_t  memory_data_reg;
  execute_data_t execute_data_out;

  memory_access dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .execute_data_reg(execute_data_reg),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_write(dreq_write),
    .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_rdata(dresp_rdata), .writeback_enable(writeback_enable),
    .m_or_e(m_or_e), .read_data(read_data), .memory_data_reg(memory_data_reg),
    .execute_data_out(execute_data_out), .stall(stall), .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  typedef struct {
    int            cyc;
    logic          sel;
    u32            rdata;
    execute_data_t rec;
    logic          aerr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic checkOutput(input string name, input logic [159:0] act,
                             input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the MIPS load/store table.
  function automatic void opInfo(input logic [5:0] op, output bit isMem,
                                 output bit isLoad, output bit isSigned,
                                 output int size);
    isMem = 1; isLoad = 0; isSigned = 0; size = 4;
    case (op)
      6'h20: begin isLoad = 1; isSigned = 1; size = 1; end
      6'h24: begin isLoad = 1; size = 1; end
      6'h21: begin isLoad = 1; isSigned = 1; size = 2; end
      6'h25: begin isLoad = 1; size = 2; end
      6'h23: begin isLoad = 1; size = 4; end
      6'h28: size = 1;
      6'h29: size = 2;
      6'h2b: size = 4;
      default: isMem = 0;
    endcase
  endfunction

  function automatic u32 modelLoad(input u32 word, input u32 addr, input int size,
                                   input bit isSigned);
    longint unsigned v, mask;
    v = word;
    v = v >> (8 * (addr % 4));
    mask = (64'd1 << (8 * size)) - 1;
    v = v & mask;
    if (isSigned && (((v >> (8 * size - 1)) & 1) == 1)) v = v | ~mask;
    return u32'(v);
  endfunction

  function automatic memory_data_t toMem(input execute_data_t e);
    memory_data_t m;
    m.pc = e.pc; m.instruction = e.instruction; m.alu_result = e.alu_result;
    m.write_reg = e.write_reg; m.reg_write = e.reg_write; m.mem_to_reg = e.mem_to_reg;
    return m;
  endfunction

  function automatic execute_data_t mkRec(input logic [5:0] op, input u32 addr,
                                          input u32 rt);
    execute_data_t r;
    r.pc          = $urandom;
    r.instruction = {op, 26'($urandom)};
    r.alu_result  = addr;
    r.rt_value    = rt;
    r.write_reg   = 5'($urandom);
    r.reg_write   = 1'($urandom);
    r.mem_to_reg  = 1'($urandom);
    return r;
  endfunction

  // Issue one record (called at a falling edge) and serve its memory
  // transaction: a idle cycles before addr_ok, data_ok d cycles after it.
  // noise adds stale data_ok and flush/in_valid where they must be ignored.
  task automatic applyStimulus(input execute_data_t rec, input int a, input int d,
                               input u32 rdata, input bit noise);
    bit isMem, isLoad, isSigned;
    int size;
    bit goesToMem;
    u32 addr, expWdata;
    logic [3:0] expStrobe;
    exp_t e;
    opInfo(rec.instruction[31:26], isMem, isLoad, isSigned, size);
    addr      = rec.alu_result;
    goesToMem = isMem && ((addr % size) == 0);
    e.rec     = rec;
    e.aerr    = isMem && !goesToMem;
    if (goesToMem) begin
      e.cyc   = cyc + 2 + a + d;
      e.sel   = SEL_M;
      e.rdata = isLoad ? modelLoad(rdata, addr, size, isSigned) : 32'd0;
    end else begin
      e.cyc   = cyc + 1;
      e.sel   = SEL_E;
      e.rdata = 32'd0;
    end
    sb.push_back(e);
    expStrobe = isLoad ? 4'b0000 : 4'(((1 << size) - 1) << (addr % 4));
    if (size == 1)      expWdata = (rec.rt_value & 32'hFF) * 32'h0101_0101;
    else if (size == 2) expWdata = (rec.rt_value & 32'hFFFF) * 32'h0001_0001;
    else                expWdata = rec.rt_value;

    checkOutput("in_ready_idle", in_ready, 1);
    execute_data_reg = rec;
    in_valid = 1; flush = 0; dresp_addr_ok = 0; dresp_data_ok = noise;
    dresp_rdata = $urandom;
    @(posedge clk); @(negedge clk);
    in_valid = 0; dresp_data_ok = 0;
    if (goesToMem) begin
      for (int i = 0; i <= a; i++) begin
        checkOutput("dreq_valid_addr", dreq_valid, 1);
        checkOutput("stall_addr", stall, 1);
        checkOutput("in_ready_busy", in_ready, 0);
        checkOutput("dreq_addr", dreq_addr, addr & ~32'd3);
        checkOutput("dreq_write", dreq_write, !isLoad);
        checkOutput("dreq_strobe", dreq_strobe, expStrobe);
        if (!isLoad) checkOutput("dreq_wdata", dreq_wdata, expWdata);
        if (noise) begin
          in_valid = 1; flush = 1;
          execute_data_reg = mkRec(6'h00, $urandom, $urandom);
        end
        if (i == a) begin
          dresp_addr_ok = 1; dresp_data_ok = (d == 0);
          dresp_rdata = (d == 0) ? rdata : $urandom;
        end else begin
          dresp_addr_ok = 0; dresp_data_ok = noise; dresp_rdata = $urandom;
        end
        @(posedge clk); @(negedge clk);
      end
      dresp_addr_ok = 0; dresp_data_ok = 0;
      for (int j = 1; j <= d; j++) begin
        checkOutput("dreq_valid_data", dreq_valid, 0);
        checkOutput("stall_data", stall, 1);
        dresp_data_ok = (j == d);
        dresp_rdata   = (j == d) ? rdata : $urandom;
        @(posedge clk); @(negedge clk);
      end
      dresp_data_ok = 0; in_valid = 0; flush = 0;
    end else begin
      checkOutput("dreq_valid_direct", dreq_valid, 0);
      checkOutput("stall_direct", stall, 0);
    end
  endtask

  // Monitor: every writeback pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        checkOutput("missing_wb_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (writeback_enable) begin
        if (sb.size() == 0) checkOutput("unexpected_wb", writeback_enable, 0);
        else begin
          mon_e = sb.pop_front();
          checkOutput("wb_cycle", cyc, mon_e.cyc);
          checkOutput("m_or_e", m_or_e, mon_e.sel);
          checkOutput("read_data", read_data, mon_e.rdata);
          checkOutput("execute_data_out", execute_data_out, mon_e.rec);
          checkOutput("memory_data_reg", memory_data_reg, toMem(mon_e.rec));
          checkOutput("addr_error", addr_error, mon_e.aerr);
        end
      end else if (addr_error) begin
        checkOutput("stray_addr_error", addr_error, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  logic [5:0] opTable [12] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h28,
                               6'h29, 6'h2b, 6'h00, 6'h09, 6'h22, 6'h2e};

  initial begin
    u32 addr;
    execute_data_t r;
    reset = 0; in_valid = 0; flush = 0; execute_data_reg = '0;
    dresp_addr_ok = 0; dresp_data_ok = 0; dresp_rdata = '0;
    repeat (3) @(negedge clk);

    checkOutput("rst_writeback_enable", writeback_enable, 0);
    checkOutput("rst_m_or_e", m_or_e, SEL_E);
    checkOutput("rst_read_data", read_data, 0);
    checkOutput("rst_memory_data_reg", memory_data_reg, 0);
    checkOutput("rst_execute_data_out", execute_data_out, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_addr_error", addr_error, 0);
    checkOutput("rst_dreq_valid", dreq_valid, 0);
    checkOutput("rst_dreq_addr", dreq_addr, 0);
    checkOutput("rst_dreq_strobe", dreq_strobe, 0);
    checkOutput("rst_dreq_write", dreq_write, 0);
    checkOutput("rst_dreq_wdata", dreq_wdata, 0);
    reset = 1;
    @(negedge clk);

    // Directed cases.
    applyStimulus(mkRec(6'h00, 32'h0000_1234, 32'h5), 0, 0, 32'h0, 0);
    applyStimulus(mkRec(6'h20, 32'h0000_0103, 32'h0), 0, 0, 32'h80FF_FFFF, 0);
    applyStimulus(mkRec(6'h29, 32'h0000_0202, 32'hABCD_1234), 2, 2, 32'h0, 0);
    applyStimulus(mkRec(6'h23, 32'h0000_0101, 32'h0), 0, 0, 32'h0, 0);
    for (int k = 0; k < 3; k++)
      applyStimulus(mkRec(6'h09, $urandom, $urandom), 0, 0, 32'h0, 0);

    // Flush while idle: nothing is accepted.
    execute_data_reg = mkRec(6'h00, 32'h77, 32'h1);
    in_valid = 1; flush = 1;
    @(posedge clk); @(negedge clk);
    checkOutput("flush_in_ready", in_ready, 1);
    checkOutput("flush_no_wb", writeback_enable, 0);
    in_valid = 0; flush = 0;

    // Flush during the address phase is ignored.
    applyStimulus(mkRec(6'h2b, 32'h0000_0400, 32'hCAFE_F00D), 2, 1, 32'h0, 1);

    // Reset in DATA discards the in-flight load.
    execute_data_reg = mkRec(6'h23, 32'h0000_0300, 32'h0);
    in_valid = 1;
    @(posedge clk); @(negedge clk);
    in_valid = 0; dresp_addr_ok = 1;
    @(posedge clk); @(negedge clk);
    dresp_addr_ok = 0;
    checkOutput("data_state_stall", stall, 1);
    #2 reset = 0;
    #1;
    checkOutput("async_rst_dreq_valid", dreq_valid, 0);
    checkOutput("async_rst_stall", stall, 0);
    checkOutput("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1;
    applyStimulus(mkRec(6'h24, 32'h0000_0502, 32'h0), 2, 1, 32'h1234_5678, 1);

    // Randomized traffic.
    for (int k = 0; k < 250; k++) begin
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      r = mkRec(opTable[$urandom_range(0, 11)], addr, $urandom);
      applyStimulus(r, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                    1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
